filtros_engine: RTL and testbench
=================================

Name: filtros_engine

Overview:
- Parametrised hardware successor to the software-run classic filter flow: a fixed-function pixel filter engine.
- Reads a source image from the shared data memory, applies one of four selectable filters and writes the result to a destination region of the same memory.
- Sits beside the processor on a single-port memory master interface; the display read port remains separate.
- Start/busy/done handshake; mode and parameter are latched at start.

Parameters:
- PIX_W, 8, pixel width in bits (one pixel per memory word).
- ADDR_W, 16, memory address width.
- IMG_W, 160, image width in pixels (must be >= 2).
- IMG_H, 120, image height in pixels (must be >= 1).
- SRC_BASE, 0, word address of source pixel (0,0).
- DST_BASE, 19200, word address of destination pixel (0,0).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- mode  in  2  0 invert, 1 threshold, 2 brighten, 3 horizontal blur.
- param  in  PIX_W  threshold level or brighten offset; ignored for modes 0 and 3.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at completion.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  write enable.
- mem_wdata  out  PIX_W  write data.
- mem_rdata  in  PIX_W  read data, valid one cycle after its address is presented.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0; all counters and window registers cleared.
- A reset asserted mid-frame abandons the frame immediately; no further writes occur.
- FSM states: IDLE, FETCH, WAIT, WRITE, FIN.
  - IDLE: on start=1, latch mode and param, clear x and y, go to FETCH.
  - FETCH: mem_addr = SRC_BASE + linear index of the pixel being fetched.
  - WAIT: capture mem_rdata at the end of this cycle.
  - WRITE: mem_addr = DST_BASE + y*IMG_W + x, mem_we=1, mem_wdata = result.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Point modes (0-2): FETCH, WAIT, WRITE per pixel. Order is raster: x increments, wrapping to 0 at IMG_W-1 and incrementing y. After the last pixel (IMG_W-1, IMG_H-1), go to FIN.
- Blur mode (3), sliding window prev/cur/next per row:
  - Row start: fetch pixel x=0; set prev=cur=p0 (left edge replicated).
  - For x < IMG_W-1: FETCH/WAIT pixel x+1 into next, WRITE x, then shift prev<=cur, cur<=next.
  - At x = IMG_W-1: next=cur (right edge replicated); WRITE only, with no fetch.
  - Each row costs exactly 3*IMG_W cycles.
- Total latency for every mode: done is high in cycle 3*IMG_W*IMG_H + 1, counting the start-accept cycle as 0.
- Arithmetic:
  - invert = (2^PIX_W - 1) - p.
  - threshold = (p >= param) ? all-ones : 0.
  - brighten = p + param, saturating to all-ones; internal sum is PIX_W+1 bits.
  - blur = (prev + 2*cur + next) >> 2; internal sum is PIX_W+2 bits, result truncated toward zero.
- start while busy: ignored. start during FIN: ignored. Changes to mode or param during a frame have no effect.
- mem_we is high only in WRITE; mem_addr holds its last value in IDLE.

Optional Feature:
- Macro: FILT_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 while busy completes any WRITE in progress, then goes to FIN at the next pixel boundary. done pulses and the remaining pixels are not written.
  - abort in IDLE is ignored.
- Undefined: no abort port; every frame runs to completion.

Test Plan:
- Test setup for all scenarios: IMG_W=4, IMG_H=2; source row0 = 10,20,30,40 and row1 = 0,255,128,1.
- Reset: rst=0 mid-frame (after 5 cycles) -> busy=0, mem_we=0 within the same cycle; no writes afterwards; next start runs a full frame.
- Mode 0 -> destination row0 = 245,235,225,215; done in cycle 25; exactly 8 mem_we pulses.
- Mode 1, param=128 -> row1 = 0,255,255,0. Mode 2, param=240 -> row0 = 250,255,255,255 (saturated).
- Mode 3 -> row0 = 12,20,30,37; row1 = 63,159,128,32; done in cycle 25.
- start pulsed at cycles 3 and 25 of a frame -> both ignored; single done. Back-to-back frame started the cycle after FIN completes normally.
- FILT_ABORT_EN: abort at cycle 7 -> destination pixels 0 and 1 written, pixels 2..7 untouched, done pulse follows.

Source files
------------

// File: rtl/filtros_engine_if.sv
// filtros_engine_if: start/busy/done handshake plus the single-port memory master bus of the filter engine.
// The abort request is present only when FILT_ABORT_EN is defined.
interface filtros_engine_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [1:0]        mode;
  logic [PIX_W-1:0]  param;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;
`ifdef FILT_ABORT_EN
  logic              abort;

  modport master (
    input  start, mode, param, mem_rdata, abort,
    output busy, done, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    output start, mode, param, mem_rdata, abort,
    input  busy, done, mem_addr, mem_we, mem_wdata
  );
`else
  modport master (
    input  start, mode, param, mem_rdata,
    output busy, done, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    output start, mode, param, mem_rdata,
    input  busy, done, mem_addr, mem_we, mem_wdata
  );
`endif
endinterface

// File: rtl/filtros_engine.sv
// filtros_engine: fixed-function pixel filter (invert/threshold/brighten/3-tap blur) over a shared single-port memory.
// Define FILT_ABORT_EN to add the abort request (ends the frame early at the next pixel boundary).
module filtros_engine #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned IMG_W    = 160,
  parameter int unsigned IMG_H    = 120,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 19200
) (
  input  logic              clk,
  input  logic              rst,
  filtros_engine_if.master  io_bus
);
  localparam int unsigned XW    = $clog2(IMG_W);
  localparam int unsigned YW    = $clog2(IMG_H + 1);
  localparam int unsigned SUM_W = PIX_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [1:0] M_THR  = 2'd1;
  localparam logic [1:0] M_BRI  = 2'd2;
  localparam logic [1:0] M_BLUR = 2'd3;

  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0]     X_PEN  = XW'(IMG_W - 2);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] A_SRC  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] A_DST  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] A_ROW  = ADDR_W'(IMG_W);

  logic [2:0]        r_state, w_state_n;
  logic [1:0]        r_mode, w_mode_n;
  logic [PIX_W-1:0]  r_param, w_param_n;
  logic [XW-1:0]     r_x, w_x_n;
  logic [YW-1:0]     r_y, w_y_n;
  logic [ADDR_W-1:0] r_row, w_row_n;
  logic              r_lead, w_lead_n;
  logic [PIX_W-1:0]  r_prev, w_prev_n;
  logic [PIX_W-1:0]  r_cur, w_cur_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic              r_we, w_we_n;
  logic [PIX_W-1:0]  r_wdata, w_wdata_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;

  logic              w_go_fetch, w_go_write, w_go_fin;
  logic              w_abort;
  logic [PIX_W:0]    w_bri_sum;
  logic [SUM_W-1:0]  w_blur_mid, w_blur_edge;
  logic [PIX_W-1:0]  w_point;

`ifdef FILT_ABORT_EN
  assign w_abort = io_bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Window sums: mid uses the pixel arriving from memory as next, edge replicates cur on the right.
  assign w_bri_sum   = {1'b0, io_bus.mem_rdata} + {1'b0, r_param};
  assign w_blur_mid  = SUM_W'(r_prev) + SUM_W'({r_cur, 1'b0}) + SUM_W'(io_bus.mem_rdata);
  assign w_blur_edge = SUM_W'(r_prev) + SUM_W'({r_cur, 1'b0}) + SUM_W'(r_cur);

  always_comb begin
    case (r_mode)
      M_THR:   w_point = (io_bus.mem_rdata >= r_param) ? '1 : '0;
      M_BRI:   w_point = w_bri_sum[PIX_W] ? '1 : w_bri_sum[PIX_W-1:0];
      default: w_point = ~io_bus.mem_rdata;
    endcase
  end

  // Next-state and registered-output decode.
  always_comb begin
    w_state_n  = r_state;
    w_mode_n   = r_mode;
    w_param_n  = r_param;
    w_x_n      = r_x;
    w_y_n      = r_y;
    w_row_n    = r_row;
    w_lead_n   = r_lead;
    w_prev_n   = r_prev;
    w_cur_n    = r_cur;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_go_fetch = 1'b0;
    w_go_write = 1'b0;
    w_go_fin   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_mode_n   = io_bus.mode;
          w_param_n  = io_bus.param;
          w_x_n      = '0;
          w_y_n      = '0;
          w_row_n    = '0;
          w_lead_n   = (io_bus.mode == M_BLUR);
          w_go_fetch = 1'b1;
        end
      end
      S_FETCH: w_state_n = S_WAIT;
      S_WAIT: begin
        if (r_mode != M_BLUR) begin
          w_wdata_n  = w_point;
          w_go_write = 1'b1;
        end else if (r_lead) begin
          w_prev_n   = io_bus.mem_rdata;
          w_cur_n    = io_bus.mem_rdata;
          w_lead_n   = 1'b0;
          w_go_fetch = 1'b1;
        end else begin
          w_wdata_n  = w_blur_mid[SUM_W-1:2];
          w_prev_n   = r_cur;
          w_cur_n    = io_bus.mem_rdata;
          w_go_write = 1'b1;
        end
      end
      S_WRITE: begin
        if (r_x == X_LAST) begin
          if (r_y == Y_LAST) begin
            w_go_fin = 1'b1;
          end else begin
            w_x_n      = '0;
            w_y_n      = r_y + YW'(1);
            w_row_n    = r_row + A_ROW;
            w_lead_n   = (r_mode == M_BLUR);
            w_go_fetch = 1'b1;
          end
        end else begin
          w_x_n = r_x + XW'(1);
          // Last blur pixel of a row needs no fetch: right edge is replicated.
          if (r_mode == M_BLUR && r_x == X_PEN) begin
            w_wdata_n  = w_blur_edge[SUM_W-1:2];
            w_go_write = 1'b1;
          end else begin
            w_go_fetch = 1'b1;
          end
        end
      end
      S_FIN:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    if (w_abort && r_busy) begin
      w_go_fetch = 1'b0;
      w_go_write = 1'b0;
      w_go_fin   = 1'b1;
    end

    if (w_go_fetch) begin
      w_state_n = S_FETCH;
      w_addr_n  = A_SRC + w_row_n + ADDR_W'(w_x_n) + ADDR_W'(w_mode_n == M_BLUR && !w_lead_n);
    end
    if (w_go_write) begin
      w_state_n = S_WRITE;
      w_addr_n  = A_DST + w_row_n + ADDR_W'(w_x_n);
    end
    if (w_go_fin) begin
      w_state_n = S_FIN;
    end

    w_we_n   = w_go_write;
    w_done_n = w_go_fin;
    w_busy_n = w_go_fetch | w_go_write | (w_state_n == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_param <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_row   <= '0;
      r_lead  <= 1'b0;
      r_prev  <= '0;
      r_cur   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_mode  <= w_mode_n;
      r_param <= w_param_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_row   <= w_row_n;
      r_lead  <= w_lead_n;
      r_prev  <= w_prev_n;
      r_cur   <= w_cur_n;
      r_addr  <= w_addr_n;
      r_we    <= w_we_n;
      r_wdata <= w_wdata_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.mem_we    = r_we;
  assign io_bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_filtros_engine.sv
// tb_filtros_engine: drives filtros_engine on a small 4x2 image with a bench-side memory and a
// reference filter model computed directly from pixel neighbourhoods.
module tb_filtros_engine;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned IMG_W    = 4;
  localparam int unsigned IMG_H    = 2;
  localparam int unsigned SRC_BASE = 32;
  localparam int unsigned DST_BASE = 200;
  localparam int          NPIX     = IMG_W * IMG_H;
  localparam int          LAT      = 3 * NPIX + 1;
  localparam int          PMAX     = (1 << PIX_W) - 1;

  logic clk = 1'b0;
  logic rst;

  filtros_engine_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  filtros_engine #(
    .PIX_W(PIX_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0] src_img [NPIX];
  logic [PIX_W-1:0] dst_img [NPIX];
  int wr_cnt [NPIX];
  int n_wr    = 0;
  int n_stray = 0;
  int n_chk   = 0;
  int n_fail  = 0;
  int wr_idx, rd_idx;

  assign wr_idx = int'(bus.mem_addr) - int'(DST_BASE);
  assign rd_idx = int'(bus.mem_addr) - int'(SRC_BASE);

  // Single-port memory: registered read, write-enable stores into the destination image.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      n_wr <= n_wr + 1;
      if (wr_idx >= 0 && wr_idx < NPIX) begin
        dst_img[wr_idx] <= bus.mem_wdata;
        wr_cnt[wr_idx]  <= wr_cnt[wr_idx] + 1;
      end else begin
        n_stray <= n_stray + 1;
      end
    end
    bus.mem_rdata <= (rd_idx >= 0 && rd_idx < NPIX) ? src_img[rd_idx] : 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int src_at(input int x, input int y);
    int cx;
    cx = (x < 0) ? 0 : ((x >= IMG_W) ? IMG_W - 1 : x);
    return int'(src_img[y * IMG_W + cx]);
  endfunction

  function automatic int model_pix(input int m, input int prm, input int x, input int y);
    int p;
    p = src_at(x, y);
    case (m)
      0:       return PMAX - p;
      1:       return (p >= prm) ? PMAX : 0;
      2:       return (p + prm > PMAX) ? PMAX : p + prm;
      default: return (src_at(x - 1, y) + 2 * p + src_at(x + 1, y)) / 4;
    endcase
  endfunction

  task automatic load_plan_image();
    int pl [NPIX];
    pl = '{10, 20, 30, 40, 0, 255, 128, 1};
    for (int i = 0; i < NPIX; i++) src_img[i] = PIX_W'(pl[i]);
  endtask

  task automatic chk_dst(input string tag, input int exp [NPIX]);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("%s_px%0d", tag, i), 32'(dst_img[i]), exp[i]);
  endtask

  // One full frame from the current negedge; optional ignored start pulses and mid-frame mode/param changes.
  task automatic run_frame(input int m, input int prm, input bit poke);
    int done_cyc;
    int wr0;
    int cnt0 [NPIX];
    wr0 = n_wr;
    for (int i = 0; i < NPIX; i++) cnt0[i] = wr_cnt[i];
    bus.mode  = 2'(m);
    bus.param = PIX_W'(prm);
    bus.start = 1'b1;
    done_cyc  = 0;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(negedge clk);
      bus.start = poke && (c == 3 || c == LAT);
      if (poke && c == 5) begin
        bus.mode  = 2'(m + 1);
        bus.param = PIX_W'(prm + 77);
      end
      if (c == 1) chk("busy_after_start", 32'(bus.busy), 1);
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    chk($sformatf("m%0d_done_cycle", m), done_cyc, LAT);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_after_fin", 32'(bus.busy), 0);
    chk("addr_hold_idle", 32'(bus.mem_addr), DST_BASE + NPIX - 1);
    chk($sformatf("m%0d_nwrites", m), n_wr - wr0, NPIX);
    for (int i = 0; i < NPIX; i++) begin
      chk($sformatf("m%0d_p%0d_px%0d", m, prm, i), 32'(dst_img[i]),
          model_pix(m, prm, i % IMG_W, i / IMG_W));
      chk($sformatf("m%0d_wrcnt%0d", m, i), wr_cnt[i] - cnt0[i], 1);
    end
  endtask

  initial begin
    int kat [NPIX];
    int wr0;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.param = '0;
`ifdef FILT_ABORT_EN
    bus.abort = 1'b0;
`endif
    load_plan_image();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted mid-frame abandons it.
    bus.mode  = 2'd0;
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_we", 32'(bus.mem_we), 0);
    chk("midrst_addr", 32'(bus.mem_addr), 0);
    wr0 = n_wr;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("midrst_no_writes", n_wr - wr0, 0);
    chk("midrst_idle_busy", 32'(bus.busy), 0);

    // Known-answer frames, back to back, with ignored start pulses on two of them.
    run_frame(0, 0, 1'b1);
    kat = '{245, 235, 225, 215, 255, 0, 127, 254};
    chk_dst("kat_inv", kat);
    run_frame(1, 128, 1'b0);
    kat = '{0, 0, 0, 0, 0, 255, 255, 0};
    chk_dst("kat_thr", kat);
    run_frame(2, 240, 1'b0);
    kat = '{250, 255, 255, 255, 240, 255, 255, 241};
    chk_dst("kat_bri", kat);
    run_frame(3, 0, 1'b1);
    kat = '{12, 20, 30, 37, 63, 159, 128, 32};
    chk_dst("kat_blur", kat);

    // Randomised images, modes and parameters.
    for (int t = 0; t < 16; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int i = 0; i < NPIX; i++) src_img[i] = PIX_W'($urandom_range(0, PMAX));
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, PMAX)), 1'($urandom_range(0, 1)));
    end

`ifdef FILT_ABORT_EN
    begin
      int done_cyc;
      int cnt0 [NPIX];
      load_plan_image();
      bus.abort = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_idle_busy", 32'(bus.busy), 0);
      bus.abort = 1'b0;
      for (int i = 0; i < NPIX; i++) cnt0[i] = wr_cnt[i];
      bus.mode  = 2'd0;
      bus.start = 1'b1;
      done_cyc  = 0;
      for (int c = 1; c <= LAT + 8; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = (c == 7);
        if (bus.done) begin
          done_cyc = c;
          break;
        end
      end
      bus.abort = 1'b0;
      chk("abort_done_seen", 32'(done_cyc != 0), 1);
      for (int i = 0; i < NPIX; i++)
        chk($sformatf("abort_wrcnt%0d", i), wr_cnt[i] - cnt0[i], (i < 2) ? 1 : 0);
      @(negedge clk);
      chk("abort_busy_after", 32'(bus.busy), 0);
      run_frame(3, 0, 1'b0);
    end
`endif

    chk("stray_writes", n_stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
